axi_rd_slv: RTL and testbench

AXI_RD_SLV -- requirements
Module: axi_rd_slv

---
 rtl/axi_rd_slv_pkg.sv | 96 +++++++++
 rtl/axi_sync_fifo.sv | 80 ++++++++
 rtl/axi_rd_slv.sv | 150 +++++++++++++++
 tb/tb_axi_rd_slv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_slv_pkg.sv
// Shared AXI define block plus the request type and address/response helpers
// used by the AXI read slave.
`ifndef AXI_DEFINES_SVH
`define AXI_DEFINES_SVH
`define AXI_ID_WIDTH    4
`define AXI_ADDR_WIDTH  32
`define AXI_DATA_WIDTH  32
`define AXI_LEN_WIDTH   8
`define AXI_SIZE_WIDTH  3
`define AXI_BURST_WIDTH 2
`define AXI_RESP_WIDTH  2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package axi_rd_slv_pkg;

  localparam int ID_W    = `AXI_ID_WIDTH;
  localparam int ADDR_W  = `AXI_ADDR_WIDTH;
  localparam int DATA_W  = `AXI_DATA_WIDTH;
  localparam int LEN_W   = `AXI_LEN_WIDTH;
  localparam int SIZE_W  = `AXI_SIZE_WIDTH;
  localparam int BURST_W = `AXI_BURST_WIDTH;
  localparam int RESP_W  = `AXI_RESP_WIDTH;

  localparam logic [BURST_W-1:0] BURST_FIXED = `AXI_BURST_FIXED;
  localparam logic [BURST_W-1:0] BURST_INCR  = `AXI_BURST_INCR;
  localparam logic [BURST_W-1:0] BURST_WRAP  = `AXI_BURST_WRAP;
  localparam logic [RESP_W-1:0]  RESP_OKAY   = `AXI_RESP_OKAY;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = `AXI_RESP_SLVERR;
  localparam logic [RESP_W-1:0]  RESP_DECERR = `AXI_RESP_DECERR;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_req_t;

  function automatic logic [ADDR_W-1:0] beat_bytes(input logic [SIZE_W-1:0] size);
    return ADDR_ONE << size;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0]  addr,
    input logic [LEN_W-1:0]   len,
    input logic [SIZE_W-1:0]  size,
    input logic [BURST_W-1:0] burst
  );
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] wb;
    bytes = beat_bytes(size);
    wb    = (ADDR_W'(len) + ADDR_ONE) * bytes;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = (addr & ~(bytes - ADDR_ONE)) + bytes;
      BURST_WRAP:  next_addr = (addr & ~(wb - ADDR_ONE)) | ((addr + bytes) & (wb - ADDR_ONE));
      default:     next_addr = addr;
    endcase
  endfunction

  // Decode error wins over protocol errors so an out-of-range beat is always DECERR.
  function automatic logic [RESP_W-1:0] beat_resp(
    input logic [ADDR_W-1:0]  addr,
    input logic [LEN_W-1:0]   len,
    input logic [SIZE_W-1:0]  size,
    input logic [BURST_W-1:0] burst,
    input int unsigned        mem_bytes
  );
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    if (addr >= ADDR_W'(mem_bytes)) begin
      beat_resp = RESP_DECERR;
    end else if ((burst == 2'b11) || bad_wrap ||
                 (beat_bytes(size) > ADDR_W'(DATA_W / 8))) begin
      beat_resp = RESP_SLVERR;
    end else begin
      beat_resp = RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// In-order synchronous FIFO with full/empty/count outputs; DEPTH must be a
// power of two so the pointers wrap naturally.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/axi_rd_slv.sv
// AXI read slave: queues AR requests in order and returns each burst's beat
// address as read data, with per-beat decode/protocol response.
module axi_rd_slv
  import axi_rd_slv_pkg::*;
#(
  parameter int AR_DEPTH  = 4,
  parameter int MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    axi_slv_arid,
  input  logic [ADDR_W-1:0]  axi_slv_araddr,
  input  logic [LEN_W-1:0]   axi_slv_arlen,
  input  logic [SIZE_W-1:0]  axi_slv_arsize,
  input  logic [BURST_W-1:0] axi_slv_arburst,
  input  logic               axi_slv_arvalid,
  output logic               axi_slv_arready,
  output logic [ID_W-1:0]    axi_slv_rid,
  output logic [DATA_W-1:0]  axi_slv_rdata,
  output logic [RESP_W-1:0]  axi_slv_rresp,
  output logic               axi_slv_rlast,
  output logic               axi_slv_rvalid,
  input  logic               axi_slv_rready
);

  localparam int CNT_W = $clog2(AR_DEPTH) + 1;

  state_e             state_q, state_d;
  ar_req_t            ar_req_s, head_s;
  logic               full_s, empty_s;
  logic [CNT_W-1:0]   count_s;
  logic               avail_q, head_avail_s;
  logic               push_s, pop_s, r_hs_s;
  logic               rvalid_s, rlast_s;
  logic [RESP_W-1:0]  rresp_s;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q, beats_q;
  logic [SIZE_W-1:0]  size_q;
  logic [BURST_W-1:0] burst_q;

  assign ar_req_s = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arsize, axi_slv_arburst};
  assign push_s   = axi_slv_arvalid & ~full_s;
  assign axi_slv_arready = ~full_s;

  axi_sync_fifo #(
    .WIDTH ($bits(ar_req_t)),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (ar_req_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // A freshly written entry becomes eligible one cycle later, which keeps the
  // AR push path out of the R-side load path.
  assign head_avail_s = avail_q & (count_s != {CNT_W{1'b0}});
  assign r_hs_s       = rvalid_s & axi_slv_rready;

  // Registered view of queue occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q <= 1'b0;
    end else begin
      avail_q <= ~empty_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (head_avail_s) begin
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (r_hs_s && rlast_s && !head_avail_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: R handshake qualifiers and the queue pop strobe.
  always_comb begin
    rvalid_s = 1'b0;
    rlast_s  = 1'b0;
    rresp_s  = RESP_OKAY;
    pop_s    = 1'b0;
    if (state_q == ST_BURST) begin
      rvalid_s = 1'b1;
      rlast_s  = (beats_q == {LEN_W{1'b0}});
      rresp_s  = beat_resp(addr_q, len_q, size_q, burst_q, MEM_BYTES);
      pop_s    = axi_slv_rready & rlast_s & head_avail_s;
    end else begin
      pop_s    = head_avail_s;
    end
  end

  // Burst registers: load on pop, advance on each non-last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= {ID_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      beats_q <= {LEN_W{1'b0}};
      size_q  <= {SIZE_W{1'b0}};
      burst_q <= {BURST_W{1'b0}};
    end else if (pop_s) begin
      id_q    <= head_s.id;
      addr_q  <= head_s.addr;
      len_q   <= head_s.len;
      beats_q <= head_s.len;
      size_q  <= head_s.size;
      burst_q <= head_s.burst;
    end else if (r_hs_s && !rlast_s) begin
      addr_q  <= next_addr(addr_q, len_q, size_q, burst_q);
      beats_q <= beats_q - LEN_W'(1);
    end
  end

  assign axi_slv_rvalid = rvalid_s;
  assign axi_slv_rlast  = rlast_s;
  assign axi_slv_rresp  = rresp_s;
  assign axi_slv_rid    = rvalid_s ? id_q : {ID_W{1'b0}};
  assign axi_slv_rdata  = rvalid_s ? DATA_W'(addr_q) : {DATA_W{1'b0}};

endmodule

// File: tb/tb_axi_rd_slv.sv
// Directed self-checking bench for axi_rd_slv.
module tb_axi_rd_slv;
  import axi_rd_slv_pkg::*;

  localparam int AR_DEPTH  = 4;
  localparam int MEM_BYTES = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ID_W-1:0]    arid = '0;
  logic [ADDR_W-1:0]  araddr = '0;
  logic [LEN_W-1:0]   arlen = '0;
  logic [SIZE_W-1:0]  arsize = '0;
  logic [BURST_W-1:0] arburst = '0;
  logic               arvalid = 1'b0;
  logic               arready;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_addr [16];
  logic [1:0]  exp_resp [16];

  always #5 clk = ~clk;

  axi_rd_slv #(.AR_DEPTH(AR_DEPTH), .MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int c = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    while (!arready && c < 50) begin
      tick;
      c++;
    end
    check_eq("ar_accept", arready, 1);
    tick;
    arvalid = 1'b0;
  endtask

  // Receive n beats checked against exp_addr/exp_resp.
  task automatic rx_burst(input int n, input logic [3:0] id, input bit toggle, input bit chk_data,
                          input bit nobubble, input bit idle_after);
    int wait_c = 0;
    int k = 0;
    int cyc = 0;
    while (!rvalid && wait_c < 20) begin
      tick;
      wait_c++;
    end
    check_eq("rvalid_wait", rvalid, 1);
    if (nobubble) check_eq("bubble", wait_c, 0);
    while (k < n && cyc < 100) begin
      rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      check_eq("rvalid", rvalid, 1);
      if (chk_data) check_eq("rdata", rdata, exp_addr[k]);
      check_eq("rresp", rresp, exp_resp[k]);
      check_eq("rid", rid, id);
      check_eq("rlast", rlast, (k == n - 1));
      tick;
      if (rready) k++;
      cyc++;
    end
    check_eq("beats_done", k, n);
    rready = 1'b1;
    if (idle_after) check_eq("rvalid_idle", rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state, during and after reset
    #12;
    check_eq("rst_arready", arready, 1);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rresp", rresp, RESP_OKAY);
    tick;
    rst_n = 1'b1;
    tick;
    check_eq("post_rst_arready", arready, 1);
    check_eq("post_rst_rvalid", rvalid, 0);
    check_eq("post_rst_rlast", rlast, 0);

    // INCR with latency check
    rready = 1'b1;
    send_ar(4'd3, 32'h10, 8'd7, 3'd2, BURST_INCR);
    check_eq("lat_n", rvalid, 0);
    tick;
    check_eq("lat_n1", rvalid, 0);
    tick;
    check_eq("lat_n2", rvalid, 1);
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 32'h10 + 32'(4 * i);
      exp_resp[i] = RESP_OKAY;
    end
    rx_burst(8, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);

    // WRAP len=3
    send_ar(4'd1, 32'h38, 8'd3, 3'd2, BURST_WRAP);
    exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
    for (int i = 0; i < 4; i++) exp_resp[i] = RESP_OKAY;
    rx_burst(4, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);

    // WRAP len=2 is illegal
    send_ar(4'd2, 32'h00, 8'd2, 3'd2, BURST_WRAP);
    for (int i = 0; i < 3; i++) exp_resp[i] = RESP_SLVERR;
    rx_burst(3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    // FIXED with rready toggling
    send_ar(4'd5, 32'h30, 8'd3, 3'd2, BURST_FIXED);
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h30;
      exp_resp[i] = RESP_OKAY;
    end
    rx_burst(4, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);

    // Decode boundary
    send_ar(4'd4, 32'hF8, 8'd3, 3'd2, BURST_INCR);
    exp_addr[0] = 32'hF8; exp_addr[1] = 32'hFC; exp_addr[2] = 32'h100; exp_addr[3] = 32'h104;
    exp_resp[0] = RESP_OKAY; exp_resp[1] = RESP_OKAY;
    exp_resp[2] = RESP_DECERR; exp_resp[3] = RESP_DECERR;
    rx_burst(4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1);

    // Queue full: one burst stalled in service, then AR_DEPTH+1 more requests
    rready = 1'b0;
    send_ar(4'd7, 32'h80, 8'd1, 3'd2, BURST_INCR);
    c = 0;
    while (!rvalid && c < 20) begin
      tick;
      c++;
    end
    check_eq("qf_first_rvalid", rvalid, 1);
    for (int k = 1; k <= 4; k++) begin
      send_ar(4'(k), 32'(k * 32), 8'd1, 3'd2, BURST_INCR);
    end
    check_eq("qf_arready_full", arready, 0);
    arid = 4'd5; araddr = 32'hA0; arlen = 8'd1; arsize = 3'd2; arburst = BURST_INCR;
    arvalid = 1'b1;
    fork
      begin
        int w = 0;
        while (!arready && w < 50) begin
          tick;
          w++;
        end
        check_eq("qf_extra_stalled", (w >= 2), 1);
        check_eq("qf_extra_after_pop", rid, 1);
        tick;
        arvalid = 1'b0;
      end
      begin
        exp_addr[0] = 32'h80; exp_addr[1] = 32'h84;
        exp_resp[0] = RESP_OKAY; exp_resp[1] = RESP_OKAY;
        rx_burst(2, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
          exp_addr[0] = 32'(k * 32);
          exp_addr[1] = 32'(k * 32 + 4);
          rx_burst(2, 4'(k), 1'b0, 1'b1, 1'b1, (k == 5));
        end
      end
    join

    // Reset in the middle of a burst with another request queued
    rready = 1'b0;
    send_ar(4'd6, 32'h00, 8'd7, 3'd2, BURST_INCR);
    send_ar(4'd10, 32'h40, 8'd3, 3'd2, BURST_INCR);
    c = 0;
    while (!rvalid && c < 20) begin
      tick;
      c++;
    end
    rready = 1'b1;
    tick;
    tick;
    check_eq("mid_rdata_beat3", rdata, 32'h08);
    check_eq("mid_rid", rid, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", rvalid, 0);
    check_eq("mid_rst_arready", arready, 1);
    check_eq("mid_rst_rdata", rdata, 0);
    check_eq("mid_rst_rlast", rlast, 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_eq("no_replay", rvalid, 0);
    end
    send_ar(4'd9, 32'h44, 8'd0, 3'd2, BURST_INCR);
    exp_addr[0] = 32'h44;
    exp_resp[0] = RESP_OKAY;
    rx_burst(1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
